// File: rtl/axi_llc_repl_box.sv
// Victim-way selector for an N-way set-associative LLC with per-set PLRU,
// round-robin and LFSR-random replacement state.
module axi_llc_repl_box #(
  parameter int unsigned NumWays  = 8,
  parameter int unsigned NumLines = 256,
  parameter logic [15:0] LfsrSeed = 16'hACE1,
  localparam int unsigned IdxW = $clog2(NumLines),
  localparam int unsigned WayW = $clog2(NumWays)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [1:0]         mode_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [IdxW-1:0]    req_index_i,
  input  logic [NumWays-1:0] req_tag_valid_i,
  input  logic [NumWays-1:0] req_tag_dirty_i,
  input  logic [NumWays-1:0] req_spm_lock_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [NumWays-1:0] rsp_way_o,
  output logic               rsp_evict_o,
  output logic               rsp_none_o,
  input  logic               hit_valid_i,
  input  logic [IdxW-1:0]    hit_index_i,
  input  logic [NumWays-1:0] hit_way_i,
  input  logic               clear_i
);

  typedef logic [NumWays-2:0] plru_t;
  typedef logic [WayW-1:0]    way_t;

  function automatic way_t first_set(input logic [NumWays-1:0] mask);
    way_t idx;
    idx = '0;
    for (int w = NumWays - 1; w >= 0; w--) begin
      if (mask[w]) idx = way_t'(w);
    end
    return idx;
  endfunction

  function automatic way_t wrap_pick(input way_t start, input logic [NumWays-1:0] cand);
    way_t idx;
    way_t probe;
    idx = '0;
    for (int k = NumWays - 1; k >= 0; k--) begin
      probe = start + way_t'(k);
      if (cand[probe]) idx = probe;
    end
    return idx;
  endfunction

  // Heap-ordered tree walk; a node whose indicated half holds no candidate
  // is overridden so a locked subtree is never entered.
  function automatic way_t plru_pick(input plru_t bits, input logic [NumWays-1:0] cand);
    int unsigned node;
    int unsigned lo;
    int unsigned half;
    logic        lo_has;
    logic        hi_has;
    logic        go_hi;
    node = 0;
    lo   = 0;
    for (int l = 0; l < WayW; l++) begin
      half   = NumWays >> (l + 1);
      lo_has = 1'b0;
      hi_has = 1'b0;
      for (int unsigned w = 0; w < NumWays; w++) begin
        if (w >= lo && w < lo + half) lo_has |= cand[w];
        else if (w >= lo + half && w < lo + 2 * half) hi_has |= cand[w];
      end
      go_hi = bits[node] ? hi_has : !lo_has;
      if (go_hi) lo += half;
      node = 2 * node + (go_hi ? 2 : 1);
    end
    return way_t'(lo);
  endfunction

  function automatic plru_t plru_touch(input plru_t bits, input way_t way);
    plru_t       res;
    int unsigned node;
    res  = bits;
    node = 0;
    for (int l = 0; l < WayW; l++) begin
      res[node] = ~way[WayW-1-l];
      node      = 2 * node + (way[WayW-1-l] ? 2 : 1);
    end
    return res;
  endfunction

  plru_t        plru_q [NumLines];
  plru_t        plru_d [NumLines];
  way_t         rr_q   [NumLines];
  way_t         rr_d   [NumLines];
  logic [15:0]  lfsr_q, lfsr_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [NumWays-1:0] rsp_way_q, rsp_way_d;
  logic         rsp_evict_q, rsp_evict_d;
  logic         rsp_none_q, rsp_none_d;

  logic [NumWays-1:0] cand;
  logic [NumWays-1:0] invalid_cand;
  logic               all_locked;
  logic               has_invalid;
  way_t               policy_way;
  way_t               sel_way;
  way_t               hit_way;
  logic               accept;
  logic               policy_upd;
  logic               hit_upd;

  assign cand         = ~req_spm_lock_i;
  assign invalid_cand = cand & ~req_tag_valid_i;
  assign all_locked   = ~|cand;
  assign has_invalid  = |invalid_cand;
  assign req_ready_o  = !rsp_valid_q || rsp_ready_i;
  assign accept       = req_valid_i && req_ready_o;
  assign policy_upd   = accept && !all_locked && !has_invalid;
  assign hit_upd      = hit_valid_i && (|hit_way_i);
  assign hit_way      = first_set(hit_way_i);

  always_comb begin
    unique case (mode_i)
      2'b01:   policy_way = wrap_pick(rr_q[req_index_i], cand);
      2'b10:   policy_way = wrap_pick(lfsr_q[WayW-1:0], cand);
      default: policy_way = plru_pick(plru_q[req_index_i], cand);
    endcase
    sel_way = has_invalid ? first_set(invalid_cand) : policy_way;
  end

  // Victim touch is applied after the hit touch so it wins on shared nodes.
  always_comb begin
    plru_d = plru_q;
    rr_d   = rr_q;
    if (hit_upd) plru_d[hit_index_i] = plru_touch(plru_q[hit_index_i], hit_way);
    if (policy_upd) begin
      plru_d[req_index_i] = plru_touch(plru_d[req_index_i], sel_way);
      rr_d[req_index_i]   = sel_way + way_t'(1);
    end
    if (clear_i) begin
      plru_d = '{default: '0};
      rr_d   = '{default: '0};
    end
  end

  always_comb begin
    lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    rsp_valid_d = rsp_valid_q;
    rsp_way_d   = rsp_way_q;
    rsp_evict_d = rsp_evict_q;
    rsp_none_d  = rsp_none_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_none_d  = all_locked;
      rsp_way_d   = all_locked ? '0 : (NumWays'(1) << sel_way);
      rsp_evict_d = !all_locked && req_tag_valid_i[sel_way] && req_tag_dirty_i[sel_way];
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      plru_q      <= '{default: '0};
      rr_q        <= '{default: '0};
      lfsr_q      <= LfsrSeed;
      rsp_valid_q <= 1'b0;
      rsp_way_q   <= '0;
      rsp_evict_q <= 1'b0;
      rsp_none_q  <= 1'b0;
    end else begin
      plru_q      <= plru_d;
      rr_q        <= rr_d;
      lfsr_q      <= lfsr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_way_q   <= rsp_way_d;
      rsp_evict_q <= rsp_evict_d;
      rsp_none_q  <= rsp_none_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_way_o   = rsp_way_q;
  assign rsp_evict_o = rsp_evict_q;
  assign rsp_none_o  = rsp_none_q;

endmodule

// File: tb/tb_axi_llc_repl_box.sv
// Randomised and directed bench for axi_llc_repl_box, compared cycle by cycle
// against a behavioural model of the replacement rules.
module tb_axi_llc_repl_box;

  localparam int NW = 4;
  localparam int NL = 8;
  localparam int IW = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [1:0]    mode_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [IW-1:0] req_index_i;
  logic [NW-1:0] req_tag_valid_i;
  logic [NW-1:0] req_tag_dirty_i;
  logic [NW-1:0] req_spm_lock_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [NW-1:0] rsp_way_o;
  logic          rsp_evict_o;
  logic          rsp_none_o;
  logic          hit_valid_i;
  logic [IW-1:0] hit_index_i;
  logic [NW-1:0] hit_way_i;
  logic          clear_i;

  axi_llc_repl_box #(.NumWays(NW), .NumLines(NL), .LfsrSeed(SEED)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .mode_i(mode_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_index_i(req_index_i),
    .req_tag_valid_i(req_tag_valid_i), .req_tag_dirty_i(req_tag_dirty_i),
    .req_spm_lock_i(req_spm_lock_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_way_o(rsp_way_o), .rsp_evict_o(rsp_evict_o), .rsp_none_o(rsp_none_o),
    .hit_valid_i(hit_valid_i), .hit_index_i(hit_index_i), .hit_way_i(hit_way_i),
    .clear_i(clear_i)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  int            m_plru [NL][NW-1];
  int            m_ptr  [NL];
  logic [15:0]   m_lfsr;
  logic [15:0]   lfsr_taps;
  bit            e_valid, e_evict, e_none;
  logic [NW-1:0] e_way;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int s = 0; s < NL; s++) begin
      m_ptr[s] = 0;
      for (int n = 0; n < NW - 1; n++) m_plru[s][n] = 0;
    end
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ lfsr_taps) : (v >> 1);
  endfunction

  // Range-halving walk: a node bit of 0 points at the lower half [lo, lo+half).
  function automatic int plru_victim(input int s, input logic [NW-1:0] cand);
    int lo, size, node, half;
    bit low_has, high_has, go_hi;
    lo = 0; size = NW; node = 0;
    while (size > 1) begin
      half = size / 2;
      low_has = 0; high_has = 0;
      for (int w = 0; w < NW; w++) begin
        if (cand[w] && w >= lo && w < lo + half) low_has = 1;
        if (cand[w] && w >= lo + half && w < lo + size) high_has = 1;
      end
      go_hi = (m_plru[s][node] == 1) ? high_has : !low_has;
      node = go_hi ? 2 * node + 2 : 2 * node + 1;
      if (go_hi) lo += half;
      size = half;
    end
    return lo;
  endfunction

  function automatic void plru_access(input int s, input int w);
    int lo, size, node, half;
    lo = 0; size = NW; node = 0;
    while (size > 1) begin
      half = size / 2;
      if (w < lo + half) begin
        m_plru[s][node] = 1;
        node = 2 * node + 1;
      end else begin
        m_plru[s][node] = 0;
        node = 2 * node + 2;
        lo += half;
      end
      size = half;
    end
  endfunction

  function automatic void model_select(output int way, output bit none, output bit use_policy);
    logic [NW-1:0] cand;
    int start;
    cand = ~req_spm_lock_i;
    way = -1; none = 0; use_policy = 0;
    if (cand == '0) begin
      none = 1;
      return;
    end
    for (int w = 0; w < NW; w++)
      if (way < 0 && cand[w] && !req_tag_valid_i[w]) way = w;
    if (way >= 0) return;
    use_policy = 1;
    if (mode_i == 2'b01 || mode_i == 2'b10) begin
      start = (mode_i == 2'b01) ? m_ptr[req_index_i] : int'(m_lfsr) % NW;
      for (int k = 0; k < NW; k++)
        if (way < 0 && cand[(start + k) % NW]) way = (start + k) % NW;
    end else begin
      way = plru_victim(int'(req_index_i), cand);
    end
  endfunction

  // One clock cycle: check ready before the edge, advance the model, check outputs after.
  task automatic applyStimulus();
    int way;
    bit none, use_policy, accept, exp_ready;
    #1;
    exp_ready = !e_valid || rsp_ready_i;
    if (rst_ni) checkOutput("req_ready", req_ready_o, exp_ready);
    accept = rst_ni && req_valid_i && exp_ready;
    model_select(way, none, use_policy);
    @(posedge clk_i);
    if (!rst_ni) begin
      model_clear();
      m_lfsr = SEED;
      e_valid = 0; e_way = '0; e_evict = 0; e_none = 0;
    end else begin
      if (accept) begin
        e_valid = 1;
        e_none  = none;
        e_way   = '0;
        e_evict = 0;
        if (!none) begin
          e_way[way] = 1'b1;
          e_evict = req_tag_valid_i[way] && req_tag_dirty_i[way];
        end
      end else if (rsp_ready_i) begin
        e_valid = 0;
      end
      if (hit_valid_i)
        for (int w = 0; w < NW; w++)
          if (hit_way_i[w]) plru_access(int'(hit_index_i), w);
      if (accept && use_policy) begin
        plru_access(int'(req_index_i), way);
        m_ptr[req_index_i] = (way + 1) % NW;
      end
      if (clear_i) model_clear();
      m_lfsr = lfsr_step(m_lfsr);
    end
    #1;
    checkOutput("rsp_valid", rsp_valid_o, e_valid);
    if (e_valid) begin
      checkOutput("rsp_way", rsp_way_o, e_way);
      checkOutput("rsp_evict", rsp_evict_o, e_evict);
      checkOutput("rsp_none", rsp_none_o, e_none);
    end
  endtask

  task automatic idle_inputs();
    mode_i = 2'b00; req_valid_i = 0; req_index_i = '0;
    req_tag_valid_i = '1; req_tag_dirty_i = '0; req_spm_lock_i = '0;
    rsp_ready_i = 1; hit_valid_i = 0; hit_index_i = '0; hit_way_i = '0; clear_i = 0;
  endtask

  task automatic req_cycle(input int idx, input logic [NW-1:0] v, input logic [NW-1:0] d,
                           input logic [NW-1:0] l, input logic [1:0] m);
    req_valid_i = 1; req_index_i = IW'(idx);
    req_tag_valid_i = v; req_tag_dirty_i = d; req_spm_lock_i = l; mode_i = m;
    rsp_ready_i = 1;
    applyStimulus();
    req_valid_i = 0;
  endtask

  logic [NW-1:0] exp_plru [4] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};
  logic [NW-1:0] exp_rr   [4] = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};
  int            poly_exps [4] = '{16, 14, 13, 11};
  int            r;

  initial begin
    lfsr_taps = '0;
    foreach (poly_exps[i]) lfsr_taps[poly_exps[i] - 1] = 1'b1;
    e_valid = 0; e_way = '0; e_evict = 0; e_none = 0;
    model_clear();
    m_lfsr = SEED;

    idle_inputs();
    rst_ni = 0;
    applyStimulus();
    applyStimulus();
    rst_ni = 1;
    checkOutput("reset_way", rsp_way_o, 0);
    checkOutput("reset_evict", rsp_evict_o, 0);
    checkOutput("reset_none", rsp_none_o, 0);
    rsp_ready_i = 0;
    #1;
    checkOutput("reset_ready", req_ready_o, 1);
    rsp_ready_i = 1;

    foreach (exp_plru[i]) begin
      req_cycle(3, 4'hF, 4'h0, 4'h0, 2'b00);
      checkOutput("plru_seq", rsp_way_o, exp_plru[i]);
      checkOutput("plru_seq_evict", rsp_evict_o, 0);
    end

    req_cycle(3, 4'b1011, 4'hF, 4'h0, 2'b00);
    checkOutput("invalid_prio", rsp_way_o, 4'b0100);
    checkOutput("invalid_evict", rsp_evict_o, 0);
    req_cycle(3, 4'hF, 4'h0, 4'h0, 2'b00);
    checkOutput("invalid_no_update", rsp_way_o, 4'b0001);

    req_cycle(4, 4'hF, 4'h0, 4'hF, 2'b00);
    checkOutput("all_locked_none", rsp_none_o, 1);
    checkOutput("all_locked_way", rsp_way_o, 0);
    req_cycle(6, 4'hF, 4'b0001, 4'h0, 2'b00);
    checkOutput("dirty_way", rsp_way_o, 4'b0001);
    checkOutput("dirty_evict", rsp_evict_o, 1);

    foreach (exp_rr[i]) begin
      req_cycle(0, 4'hF, 4'h0, 4'b0010, 2'b01);
      checkOutput("rr_seq", rsp_way_o, exp_rr[i]);
    end
    applyStimulus();

    req_valid_i = 1; req_index_i = 3'd1; mode_i = 2'b01;
    req_tag_valid_i = '1; req_spm_lock_i = '0; rsp_ready_i = 0;
    applyStimulus();
    checkOutput("bp_first", rsp_way_o, 4'b0001);
    repeat (3) begin
      applyStimulus();
      checkOutput("bp_ready_low", req_ready_o, 0);
      checkOutput("bp_hold", rsp_way_o, 4'b0001);
    end
    rsp_ready_i = 1;
    applyStimulus();
    checkOutput("bp_second", rsp_way_o, 4'b0010);
    req_valid_i = 0;
    applyStimulus();

    hit_valid_i = 1; hit_index_i = 3'd5; hit_way_i = 4'b0001;
    applyStimulus();
    hit_valid_i = 0; hit_way_i = '0;
    req_cycle(5, 4'hF, 4'h0, 4'h0, 2'b00);
    checkOutput("hit_plru", rsp_way_o, 4'b0100);
    clear_i = 1;
    applyStimulus();
    clear_i = 0;
    req_cycle(5, 4'hF, 4'h0, 4'h0, 2'b00);
    checkOutput("clear_plru", rsp_way_o, 4'b0001);

    req_valid_i = 1; req_index_i = 3'd2; rsp_ready_i = 0;
    applyStimulus();
    req_valid_i = 0;
    checkOutput("pending_valid", rsp_valid_o, 1);
    rst_ni = 0;
    applyStimulus();
    checkOutput("mid_reset_valid", rsp_valid_o, 0);
    rst_ni = 1;
    rsp_ready_i = 1;

    repeat (1500) begin
      rst_ni      = ($urandom_range(0, 299) != 0);
      mode_i      = 2'($urandom_range(0, 3));
      req_valid_i = ($urandom_range(0, 9) < 7);
      req_index_i = IW'($urandom_range(0, NL - 1));
      req_tag_valid_i = ($urandom_range(0, 9) < 8) ? 4'hF : NW'($urandom_range(0, 15));
      req_tag_dirty_i = NW'($urandom_range(0, 15));
      r = $urandom_range(0, 19);
      req_spm_lock_i  = (r < 15) ? 4'h0 : (r == 19) ? 4'hF : NW'($urandom_range(0, 15));
      rsp_ready_i = ($urandom_range(0, 9) < 7);
      hit_valid_i = ($urandom_range(0, 9) < 3);
      hit_index_i = IW'($urandom_range(0, NL - 1));
      r = $urandom_range(0, NW);
      hit_way_i   = (r == 0) ? '0 : NW'(1) << (r - 1);
      clear_i     = ($urandom_range(0, 39) == 0);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_llc_repl_box.md
Name: axi_llc_repl_box

Overview:
- Parametrised successor to the LLC eviction box.
- Selects the victim way for a miss in an N-way set-associative LLC.
- Keeps per-set replacement state in registers and supports three run-time policies: tree-PLRU, round-robin and LFSR-random.
- Sits between the tag-store lookup and the miss/eviction path. Requests and responses use valid/ready handshakes. Hits update the state through a separate one-cycle port.

Parameters:
- NumWays, 8, set associativity; power of two, 2..32.
- NumLines, 256, number of sets; power of two, >=2. IdxW = $clog2(NumLines), WayW = $clog2(NumWays).
- LfsrSeed, 16'hACE1, reset value of the random LFSR; must be nonzero.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- mode_i  in  2  policy: 00 PLRU, 01 round-robin, 10 LFSR; 11 behaves as PLRU.
- req_valid_i  in  1  eviction request valid.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- req_index_i  in  IdxW  set index.
- req_tag_valid_i  in  NumWays  valid bits of the set.
- req_tag_dirty_i  in  NumWays  dirty bits of the set.
- req_spm_lock_i  in  NumWays  SPM-locked ways; never selected.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_way_o  out  NumWays  one-hot victim; 0 when rsp_none_o is set.
- rsp_evict_o  out  1  victim is valid and dirty, so write-back is needed.
- rsp_none_o  out  1  all ways locked; no victim.
- hit_valid_i  in  1  hit access notification.
- hit_index_i  in  IdxW  set of the hit.
- hit_way_i  in  NumWays  one-hot hit way; all-zero means no update.
- clear_i  in  1  one-cycle pulse that zeroes all replacement state.

Behaviour:
- **Reset** (rst_ni low at a clock edge):
  - rsp_valid_o=0, rsp_way_o=0, rsp_evict_o=0, rsp_none_o=0, req_ready_o=1.
  - All PLRU bits=0, all round-robin pointers=0, LFSR=LfsrSeed.
  - A pending response is dropped.
- **Handshake:**
  - req_ready_o = !rsp_valid_o | rsp_ready_i.
  - The request is accepted on req_valid_i & req_ready_o. The response is registered and appears the next cycle (latency 1).
  - The response holds stable until rsp_valid_o & rsp_ready_i.
  - Back-to-back throughput is one request per cycle.
- **Selection**, in priority order, with candidates = ~req_spm_lock_i:
  - (1) If all ways are locked: rsp_none_o=1, rsp_way_o=0, rsp_evict_o=0, and no state update.
  - (2) Otherwise the lowest-index candidate way that is invalid. No policy state update.
  - (3) Otherwise the policy victim.
- **PLRU policy:**
  - NumWays-1 bits per set, heap-ordered, node 0 = root.
  - A node bit of 0 means the victim lies in the lower half.
  - Descend from the root. At each node, if the indicated subtree has no candidate, take the other subtree.
  - On a victim or hit access to way w, set every node on w's path to point away from w.
- **Round-robin policy:**
  - WayW-bit pointer per set.
  - Victim = first candidate at or after the pointer, wrapping modulo NumWays.
  - On acceptance, pointer = victim+1 mod NumWays.
  - Hits do not change the pointer.
- **LFSR policy:**
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, advancing every cycle.
  - Start = lfsr[WayW-1:0]. Victim = first candidate at or after start, wrapping.
- **Write-back flag:** rsp_evict_o = tag_valid & tag_dirty of the victim.
- **State updates:**
  - Applied at the accepting clock edge.
  - Selection uses the pre-edge state.
  - PLRU and round-robin state update in every mode, so switching mode never needs re-initialisation.
  - mode_i is sampled at acceptance.
- **Simultaneous hit and request to the same set:**
  - Both updates are applied.
  - Where PLRU nodes overlap, the victim update wins.
- **Simultaneous clear_i and update:** clear wins; all state becomes 0. clear_i does not affect an in-flight response or the LFSR.
- **Invariants:**
  - rsp_way_o is always one-hot or zero.
  - A locked way is never selected.
  - An invalid, unlocked way always has priority over the policy victim.

Test Plan:
- **PLRU sequence:** NumWays=4, mode 00, all valid, no lock, dirty=0, four requests to index 3 → rsp_way_o 0001, 0100, 0010, 1000; rsp_evict_o=0.
- **Invalid priority:** tag_valid=1011, dirty=1111 → way 0100, rsp_evict_o=0, and the PLRU bits of that set are unchanged.
- **All locked / dirty victim:**
  - spm_lock=1111 → rsp_none_o=1, rsp_way_o=0000.
  - Then lock=0000, all valid, dirty=0001, fresh set → way 0001, rsp_evict_o=1.
- **Round-robin:** mode 01, lock=0010, all valid, four requests to index 0 → 0001, 0100, 1000, 0001.
- **Backpressure:**
  - rsp_ready_i=0 for 3 cycles with req_valid_i held high → response stable, req_ready_o=0, no second state update.
  - Releasing ready → second response one cycle later.
- **Hit/clear:**
  - Hit way 0001 on index 5, then request index 5 (PLRU) → 0100.
  - clear_i, then request → 0001.
  - rst_ni low mid-response → rsp_valid_o=0 on the next edge.
